// File: rtl/reg_file_if.sv
// Bus bundle for the three-port register file: one write port and two
// combinational read ports. The datapath side uses the master modport, the
// register file itself uses the slave modport.
//
// Handshake: there is no valid/ready pair on this bus. A write is offered by
// holding we=1 with waddr/wdata stable around the falling edge of clk and is
// always accepted on that edge. Reads are unconditional and combinational:
// rdataN follows raddrN and the addressed register with zero latency.
interface reg_file_if #(
    parameter int WIDTH = 32,
    parameter int AW    = 5
);
    logic             we;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] wdata;
    logic [AW-1:0]    raddr1;
    logic [AW-1:0]    raddr2;
    logic [WIDTH-1:0] rdata1;
    logic [WIDTH-1:0] rdata2;

    modport master (
        output we,
        output waddr,
        output wdata,
        output raddr1,
        output raddr2,
        input  rdata1,
        input  rdata2
    );

    modport slave (
        input  we,
        input  waddr,
        input  wdata,
        input  raddr1,
        input  raddr2,
        output rdata1,
        output rdata2
    );
endinterface

// File: rtl/reg_file.sv
// Three-port register file for the single-cycle datapath.
// Registers 1..NREG-1 are falling-edge, enable-gated flops, so a write
// committed mid-cycle is visible to the combinational read muxes in the
// second half of the same cycle without any forwarding path. Index 0 has no
// storage and always reads zero; writes to it fall on the floor.
module reg_file #(
    parameter int WIDTH = 32,
    parameter int NREG  = 32,
    parameter int AW    = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    reg_file_if.slave   bus
);

    logic [AW-1:0]    w_waddr;
    logic [AW-1:0]    w_raddr1;
    logic [AW-1:0]    w_raddr2;
    logic [WIDTH-1:0] w_rd_vec [NREG];

    assign w_waddr  = bus.waddr;
    assign w_raddr1 = bus.raddr1;
    assign w_raddr2 = bus.raddr2;

    // Index 0 is the hardwired zero register: a constant mux leg, no flop.
    assign w_rd_vec[0] = '0;

    genvar gi;
    for (gi = 1; gi < NREG; gi++) begin : g_reg
        logic             w_en;
        logic [WIDTH-1:0] r_q;

        // One-hot decode leg for this index, qualified by we. With we low the
        // address and data values cannot reach any enable.
        assign w_en = bus.we & (w_waddr == AW'(gi));

        // Falling-edge storage with async clear; a falling edge that lands
        // while rst_n is still low takes the clear branch, dropping the write.
        always_ff @(negedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_q <= '0;
            end else if (w_en) begin
                r_q <= bus.wdata;
            end
        end

        assign w_rd_vec[gi] = r_q;
    end

    // Two independent NREG:1 read muxes; both ports may select the same entry.
    assign bus.rdata1 = w_rd_vec[w_raddr1];
    assign bus.rdata2 = w_rd_vec[w_raddr2];

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: reset behaviour, full write/read sweep,
// r0 immunity, same-cycle read-after-write, enable gating and reset release.
module tb_reg_file;

    localparam int WIDTH = 32;
    localparam int NREG  = 32;
    localparam int AW    = 5;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    reg_file_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

    reg_file #(
        .WIDTH (WIDTH),
        .NREG  (NREG),
        .AW    (AW)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- scoreboard ----------------
    logic [WIDTH-1:0] model [NREG];
    int n_checks;
    int n_pass;

    task automatic check(input string tag, input logic [WIDTH-1:0] got,
                         input logic [WIDTH-1:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < NREG; i++) model[i] = '0;
    endtask

    // ---------------- driver tasks ----------------
    // Drive a write in the clock-high phase; it commits on the next falling edge.
    task automatic write_reg(input int addr, input logic [WIDTH-1:0] data);
        @(posedge clk);
        #1;
        bus.we    = 1'b1;
        bus.waddr = AW'(addr);
        bus.wdata = data;
        @(negedge clk);
        #1;
        bus.we    = 1'b0;
        if (addr != 0) model[addr] = data;
    endtask

    // Read every index on both ports (port 2 sweeps in reverse) against the model.
    task automatic sweep(input string tag);
        for (int a = 0; a < NREG; a++) begin
            bus.raddr1 = AW'(a);
            bus.raddr2 = AW'(NREG - 1 - a);
            #1;
            check($sformatf("%s_p1_r%0d", tag, a), bus.rdata1, model[a]);
            check($sformatf("%s_p2_r%0d", tag, NREG - 1 - a), bus.rdata2,
                  model[NREG - 1 - a]);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_checks   = 0;
        n_pass     = 0;
        rst_n      = 1'b0;
        bus.we     = 1'b0;
        bus.waddr  = '0;
        bus.wdata  = '0;
        bus.raddr1 = '0;
        bus.raddr2 = '0;
        clear_model();

        // Reset state: any address reads zero while rst_n is low.
        #2;
        bus.raddr1 = 5'd5;
        bus.raddr2 = 5'd31;
        #1;
        check("rst_p1", bus.rdata1, 32'h0000_0000);
        check("rst_p2", bus.rdata2, 32'h0000_0000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Async reset mid-cycle wipes r5 before any clock edge.
        write_reg(5, 32'hDEAD_BEEF);
        bus.raddr1 = 5'd5;
        #1;
        check("r5_before_rst", bus.rdata1, 32'hDEAD_BEEF);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("r5_async_rst", bus.rdata1, 32'h0000_0000);
        clear_model();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Write i*0x01010101 to r1..r31, then sweep both ports.
        for (int i = 1; i < NREG; i++) write_reg(i, i * 32'h0101_0101);
        sweep("sweep");

        // r0 immunity.
        write_reg(0, 32'hFFFF_FFFF);
        bus.raddr1 = 5'd0;
        #1;
        check("r0_immune", bus.rdata1, 32'h0000_0000);
        sweep("r0_sweep");

        // Same-cycle read-after-write on r7.
        write_reg(7, 32'h1111_1111);
        @(posedge clk);
        #1;
        bus.we     = 1'b1;
        bus.waddr  = 5'd7;
        bus.wdata  = 32'h2222_2222;
        bus.raddr1 = 5'd7;
        bus.raddr2 = 5'd7;
        #1;
        check("raw_old_p1", bus.rdata1, 32'h1111_1111);
        check("raw_old_p2", bus.rdata2, 32'h1111_1111);
        @(negedge clk);
        #1;
        check("raw_new_p1", bus.rdata1, 32'h2222_2222);
        check("raw_new_p2", bus.rdata2, 32'h2222_2222);
        bus.we   = 1'b0;
        model[7] = 32'h2222_2222;

        // Enable gating: we=0 with junk address/data must never write.
        @(posedge clk);
        #1;
        bus.waddr = 5'd3;
        bus.wdata = 32'hCAFE_F00D;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk);
            #1;
            bus.waddr = AW'($urandom_range(0, NREG - 1));
            bus.wdata = $urandom;
        end
        bus.raddr1 = 5'd3;
        #1;
        check("gate_r3", bus.rdata1, 32'h0303_0303);
        sweep("gate_sweep");

        // Reset release coincident with a falling edge performs no write.
        @(posedge clk);
        #1;
        rst_n      = 1'b0;
        clear_model();
        bus.we     = 1'b1;
        bus.waddr  = 5'd9;
        bus.wdata  = 32'h0000_1234;
        bus.raddr1 = 5'd9;
        #1;
        check("rel_in_rst", bus.rdata1, 32'h0000_0000);
        @(negedge clk);
        // Nonblocking so the flops sample rst_n low on this very edge.
        rst_n <= 1'b1;
        #1;
        check("rel_edge_nowrite", bus.rdata1, 32'h0000_0000);
        @(negedge clk);
        #1;
        check("rel_next_write", bus.rdata1, 32'h0000_1234);
        bus.we   = 1'b0;
        model[9] = 32'h0000_1234;
        sweep("rel_sweep");

        // ---------------- report ----------------
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
